// File: rtl/leta_scan_ctrl_if.sv
// Host read port of the LETA scan controller: a level request with select and clear,
// answered by a one-cycle acknowledge carrying the accumulator value.
interface leta_scan_ctrl_if #(parameter int ACC_W = 12);
  logic             HOST_REQ;
  logic [1:0]       HOST_SEL;
  logic             HOST_CLR;
  logic             HOST_ACK;
  logic [ACC_W-1:0] HOST_DATA;

  // Handshake: a request is taken on any rising edge where HOST_REQ=1 and HOST_ACK=0,
  // with HOST_SEL/HOST_CLR sampled on that edge. HOST_ACK is then high for exactly one
  // cycle with HOST_DATA valid, and HOST_DATA holds until the next acknowledge.
  modport master (output HOST_REQ, HOST_SEL, HOST_CLR, input HOST_ACK, HOST_DATA);
  modport slave  (input HOST_REQ, HOST_SEL, HOST_CLR, output HOST_ACK, HOST_DATA);
endinterface

// File: rtl/leta_scan_ctrl.sv
// Round-robin scanner for the four LETA decoder counters, with per-channel signed delta
// accumulation and a host read port. Define LETA_SCAN_SATURATE_EN for clamping accumulators.
module leta_scan_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int ACC_W         = 12
) (
  input  logic            GCLK,
  input  logic            RESET_N,
  input  logic            ENABLE,
  input  logic [7:0]      LETA_DB,
  output logic [1:0]      LETA_AD,
  output logic            LETA_CS,
  output logic            FRAME,
  output logic [1:0]      state_dbg,
  leta_scan_ctrl_if.slave host
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SAMPLE = 2'd2,
    ACCUM  = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN     = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [7:0]              SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t                  state;
  logic [1:0]              ch;
  logic [7:0]              settle_cnt;
  logic [7:0]              cap;
  logic signed [7:0]       delta;
  logic [7:0]              prev [4];
  logic [3:0]              primed;
  logic signed [ACC_W-1:0] acc [4];

  logic                    accept;
  logic                    clr_hit;
  logic signed [ACC_W-1:0] delta_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_sum;

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] d);
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(a) + (ACC_W+1)'(d);
`ifdef LETA_SCAN_SATURATE_EN
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
`endif
    return s[ACC_W-1:0];
  endfunction

  assign accept    = host.HOST_REQ && !host.HOST_ACK;
  // A clear landing on the channel being accumulated restarts it from this delta.
  assign clr_hit   = accept && host.HOST_CLR && (host.HOST_SEL == ch);
  assign delta_ext = ACC_W'(delta);
  assign acc_base  = clr_hit ? '0 : acc[ch];
  assign acc_sum   = acc_add(acc_base, delta_ext);
  assign state_dbg = state;

  always_ff @(posedge GCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      ch         <= '0;
      settle_cnt <= '0;
      cap        <= '0;
      delta      <= '0;
      primed     <= '0;
      LETA_AD    <= '0;
      LETA_CS    <= 1'b1;
      FRAME      <= 1'b0;
      for (int i = 0; i < 4; i++) prev[i] <= '0;
    end else begin
      FRAME <= 1'b0;
      case (state)
        IDLE: begin
          if (ENABLE) begin
            state      <= SELECT;
            LETA_AD    <= ch;
            LETA_CS    <= 1'b0;
            settle_cnt <= '0;
          end
        end
        SELECT: begin
          if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
          else settle_cnt <= settle_cnt + 8'd1;
        end
        SAMPLE: begin
          cap   <= LETA_DB;
          delta <= primed[ch] ? $signed(LETA_DB - prev[ch]) : 8'sd0;
          state <= ACCUM;
        end
        ACCUM: begin
          prev[ch]   <= cap;
          primed[ch] <= 1'b1;
          FRAME      <= (ch == 2'd3);
          ch         <= ch + 2'd1;
          // The channel in flight always finishes; ENABLE only decides what follows.
          if (ENABLE) begin
            state      <= SELECT;
            LETA_AD    <= ch + 2'd1;
            settle_cnt <= '0;
          end else begin
            state   <= IDLE;
            LETA_CS <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge GCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      host.HOST_ACK  <= 1'b0;
      host.HOST_DATA <= '0;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else begin
      host.HOST_ACK <= accept;
      if (accept) host.HOST_DATA <= acc[host.HOST_SEL];
      for (int i = 0; i < 4; i++) begin
        if (state == ACCUM && ch == 2'(i)) acc[i] <= acc_sum;
        else if (accept && host.HOST_CLR && host.HOST_SEL == 2'(i)) acc[i] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_leta_scan_ctrl.sv
// Randomized bench for leta_scan_ctrl: a positional scan model predicts decoder strobes,
// frames and accumulator contents; host read data is checked through an expected queue.
module tb_leta_scan_ctrl;
  localparam int S         = 4;
  localparam int W         = 12;
  localparam int CH_CYC    = S + 2;
  localparam int FRAME_CYC = 4 * CH_CYC;
  localparam int MAXV      = (1 << (W - 1)) - 1;
  localparam int MINV      = -(1 << (W - 1));

  logic       GCLK    = 1'b0;
  logic       RESET_N = 1'b0;
  logic       ENABLE  = 1'b0;
  logic [7:0] LETA_DB;
  logic [1:0] LETA_AD;
  logic       LETA_CS;
  logic       FRAME;
  logic [1:0] state_dbg;
  logic [7:0] dec_cnt [4];

  leta_scan_ctrl_if #(.ACC_W(W)) hif ();

  leta_scan_ctrl #(.SETTLE_CYCLES(S), .ACC_W(W)) dut (
    .GCLK     (GCLK),
    .RESET_N  (RESET_N),
    .ENABLE   (ENABLE),
    .LETA_DB  (LETA_DB),
    .LETA_AD  (LETA_AD),
    .LETA_CS  (LETA_CS),
    .FRAME    (FRAME),
    .state_dbg(state_dbg),
    .host     (hif.slave)
  );

  // clock / decoder model
  always #5 GCLK = ~GCLK;
  assign LETA_DB = dec_cnt[LETA_AD];

  // reference model state
  int         m_acc [4];
  logic [7:0] m_prev [4];
  bit         m_primed [4];
  int         m_pos;
  bit         m_run;
  logic [1:0] m_ad;
  bit         m_cs;
  bit         m_frame;
  bit         m_ack;
  int         m_delta;
  logic [7:0] m_cap;
  bit         en_want;

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_fail;

  function automatic int fold(input int s);
    int r;
`ifdef LETA_SCAN_SATURATE_EN
    r = (s > MAXV) ? MAXV : ((s < MINV) ? MINV : s);
`else
    r = s & ((1 << W) - 1);
    if (r > MAXV) r = r - (1 << W);
`endif
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_acc[i]    = 0;
      m_prev[i]   = 8'h00;
      m_primed[i] = 1'b0;
    end
    m_pos = 0; m_run = 0; m_ad = 2'd0; m_cs = 1'b1; m_frame = 1'b0; m_ack = 1'b0;
    m_delta = 0; m_cap = 8'h00;
    exp_q.delete();
  endtask

  // Effect of the coming rising edge, given the inputs just driven.
  task automatic model_edge();
    int ch, ph, sel;
    bit accept;
    logic signed [7:0] d8;
    ch     = m_pos / CH_CYC;
    ph     = m_pos % CH_CYC;
    sel    = int'(hif.HOST_SEL);
    accept = hif.HOST_REQ && !m_ack;
    if (accept) exp_q.push_back(W'(m_acc[sel]));
    if (accept && hif.HOST_CLR) m_acc[sel] = 0;
    m_ack   = accept;
    m_frame = 1'b0;
    if (!m_run) begin
      if (ENABLE) begin
        m_run = 1'b1;
        m_cs  = 1'b0;
        m_ad  = 2'(ch);
      end
    end else if (ph == S + 1) begin
      m_acc[ch]    = fold(m_acc[ch] + m_delta);
      m_prev[ch]   = m_cap;
      m_primed[ch] = 1'b1;
      m_frame      = (ch == 3);
      m_pos        = (m_pos + 1) % FRAME_CYC;
      if (ENABLE) m_ad = 2'((ch + 1) % 4);
      else begin
        m_run = 1'b0;
        m_cs  = 1'b1;
      end
    end else begin
      if (ph == S) begin
        m_cap   = dec_cnt[ch];
        d8      = m_cap - m_prev[ch];
        m_delta = m_primed[ch] ? int'(d8) : 0;
      end
      m_pos = m_pos + 1;
    end
  endtask

  task automatic check_outputs(input bit data_zero);
    check("leta_cs", LETA_CS, m_cs);
    check("leta_ad", LETA_AD, m_ad);
    check("frame", FRAME, m_frame);
    check("host_ack", hif.HOST_ACK, m_ack);
    if (data_zero) check("host_data_idle", hif.HOST_DATA, 0);
  endtask

  // mode 0: quiet, 1: random motion + reads with clear, 2: large motion + plain reads, 3: reads only
  task automatic drive(input int mode);
    int c;
    ENABLE = en_want;
    case (mode)
      1: begin
        if ($urandom_range(0, 3) == 0) begin
          c = $urandom_range(0, 3);
          dec_cnt[c] = dec_cnt[c] + 8'($urandom_range(0, 40)) - 8'd20;
        end
        hif.HOST_REQ = 1'($urandom_range(0, 1));
        hif.HOST_SEL = 2'($urandom_range(0, 3));
        hif.HOST_CLR = 1'($urandom_range(0, 1));
      end
      2: begin
        if (m_frame) begin
          dec_cnt[2] = dec_cnt[2] + 8'd100;
          dec_cnt[3] = dec_cnt[3] - 8'd90;
        end
        hif.HOST_REQ = 1'($urandom_range(0, 1));
        hif.HOST_SEL = 2'($urandom_range(0, 3));
        hif.HOST_CLR = 1'b0;
      end
      3: begin
        hif.HOST_REQ = 1'($urandom_range(0, 1));
        hif.HOST_SEL = 2'($urandom_range(0, 3));
        hif.HOST_CLR = 1'($urandom_range(0, 1));
      end
      default: hif.HOST_REQ = 1'b0;
    endcase
  endtask

  task automatic run_cycles(input int n, input int mode, input bit data_zero);
    for (int i = 0; i < n; i++) begin
      @(negedge GCLK);
      check_outputs(data_zero);
      drive(mode);
      model_edge();
    end
  endtask

  task automatic check_reset_values();
    check("rst_leta_cs", LETA_CS, 1);
    check("rst_leta_ad", LETA_AD, 0);
    check("rst_host_ack", hif.HOST_ACK, 0);
    check("rst_host_data", hif.HOST_DATA, 0);
    check("rst_frame", FRAME, 0);
  endtask

  // scoreboard monitor
  always @(negedge GCLK) begin
    logic [W-1:0] e;
    if (RESET_N && hif.HOST_ACK === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL host_data at %0t: ack with no read outstanding, got %0h", $time, hif.HOST_DATA);
      end else begin
        e = exp_q.pop_front();
        if (hif.HOST_DATA !== e) begin
          n_fail++;
          $display("FAIL host_data at %0t: got %0h expected %0h", $time, hif.HOST_DATA, e);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    en_want = 1'b0;
    hif.HOST_REQ = 1'b0;
    hif.HOST_SEL = 2'd0;
    hif.HOST_CLR = 1'b0;
    for (int i = 0; i < 4; i++) dec_cnt[i] = 8'h10;
    model_reset();

    // clock/reset
    repeat (3) @(negedge GCLK);
    check_reset_values();
    RESET_N = 1'b1;
    drive(0);
    model_edge();

    // idle with scanning disabled, then reads of the empty accumulators
    run_cycles(10, 0, 1'b1);
    run_cycles(12, 3, 1'b0);
    run_cycles(2, 0, 1'b0);

    // constant counts for two frames: frames at 24 and 48, no motion
    en_want = 1'b1;
    run_cycles(2 * FRAME_CYC + 2, 3, 1'b0);

    // random motion with reads and clears
    run_cycles(600, 1, 1'b0);

    // drop ENABLE during channel 2 SELECT
    for (int i = 0; i < 2 * FRAME_CYC && !(m_run && m_pos == 2 * CH_CYC + 1); i++)
      run_cycles(1, 1, 1'b0);
    check("sync_ch2_select", (m_run && m_pos == 2 * CH_CYC + 1) ? 1 : 0, 1);
    en_want = 1'b0;
    run_cycles(20, 0, 1'b0);
    check("ad_held_after_drop", LETA_AD, 2);
    check("cs_high_after_drop", LETA_CS, 1);

    // large same-sign motion past the accumulator range
    en_want = 1'b1;
    run_cycles(30 * FRAME_CYC, 2, 1'b0);
    run_cycles(40, 3, 1'b0);

    // reset mid-scan with no read outstanding
    run_cycles(3, 0, 1'b0);
    @(negedge GCLK);
    RESET_N = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    en_want = 1'b0;
    repeat (2) @(negedge GCLK);
    RESET_N = 1'b1;
    drive(0);
    model_edge();
    run_cycles(5, 0, 1'b1);
    run_cycles(12, 3, 1'b0);
    run_cycles(3, 0, 1'b0);

    check("reads_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
